// File: rtl/atm_session_ctrl.sv
// ATM card/keypad session front-end: PIN packing, authentication attempts, account lock-out, menu and eject.
// Strobe-driven with no backpressure; pin_valid, op_valid and card_eject register one cycle after their cause.
module atm_session_ctrl #(
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int NUM_ACCOUNTS   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        card_insert,
    input  logic [3:0]  card_acc_num,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        auth_done,
    input  logic        auth_ok,
    input  logic        op_sel_valid,
    input  logic [2:0]  op_sel,
    input  logic        txn_done,
    output logic [3:0]  acc_num,
    output logic [15:0] pin,
    output logic        pin_valid,
    output logic [2:0]  operation,
    output logic        op_valid,
    output logic        session_active,
    output logic        card_eject,
    output logic        locked_out,
    output logic [1:0]  fail_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PIN    = 3'd1,
        S_AUTH   = 3'd2,
        S_MENU   = 3'd3,
        S_BUSY   = 3'd4,
        S_LOCKED = 3'd5,
        S_EJECT  = 3'd6
    } state_t;

    localparam int             TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]     TRIES    = 2'(MAX_TRIES);
    localparam logic [4:0]     NACC     = 5'(NUM_ACCOUNTS);
    localparam logic [3:0]     K_CLEAR  = 4'd10;
    localparam logic [3:0]     K_ENTER  = 4'd11;
    localparam logic [3:0]     K_CANCEL = 4'd12;
    localparam logic [2:0]     OP_EXIT  = 3'd7;

    state_t                  st;
    logic [TW-1:0]           tcnt;
    logic [2:0]              dcnt;
    logic [NUM_ACCOUNTS-1:0] lock_tbl;

    logic       card_locked;
    logic       acc_bad;
    logic       key_digit;
    logic       to_hit;
    logic [1:0] fail_next;

    // Explicit compare loop keeps the 4-bit account index inside the lock table bounds.
    always_comb begin
        card_locked = 1'b0;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (card_acc_num == 4'(i)) begin
                card_locked = lock_tbl[i];
            end
        end
    end

    assign acc_bad   = ({1'b0, card_acc_num} >= NACC) || card_locked;
    assign key_digit = (key_code < 4'd10);
    assign to_hit    = (tcnt == TO_LAST);
    assign fail_next = fail_count + 2'd1;
    assign state     = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st             <= S_IDLE;
            tcnt           <= '0;
            dcnt           <= '0;
            lock_tbl       <= '0;
            acc_num        <= '0;
            pin            <= '0;
            pin_valid      <= 1'b0;
            operation      <= '0;
            op_valid       <= 1'b0;
            session_active <= 1'b0;
            card_eject     <= 1'b0;
            locked_out     <= 1'b0;
            fail_count     <= '0;
        end else begin
            pin_valid  <= 1'b0;
            op_valid   <= 1'b0;
            card_eject <= 1'b0;
            locked_out <= 1'b0;
            // Idle timer only survives a cycle spent waiting in PIN_ENTRY/MENU with no strobe.
            tcnt       <= '0;

            case (st)
                S_IDLE: begin
                    if (card_insert) begin
                        acc_num <= card_acc_num;
                        if (acc_bad) begin
                            st         <= S_LOCKED;
                            locked_out <= 1'b1;
                        end else begin
                            st         <= S_PIN;
                            pin        <= '0;
                            dcnt       <= '0;
                            fail_count <= '0;
                        end
                    end
                end

                S_PIN: begin
                    if (key_valid) begin
                        if (key_digit) begin
                            if (dcnt != 3'd4) begin
                                pin  <= {pin[11:0], key_code};
                                dcnt <= dcnt + 3'd1;
                            end
                        end else if (key_code == K_CLEAR) begin
                            pin  <= '0;
                            dcnt <= '0;
                        end else if (key_code == K_ENTER) begin
                            if (dcnt == 3'd4) begin
                                pin_valid <= 1'b1;
                                st        <= S_AUTH;
                            end
                        end else if (key_code == K_CANCEL) begin
                            st         <= S_EJECT;
                            card_eject <= 1'b1;
                        end
                    end else if (to_hit) begin
                        st         <= S_EJECT;
                        card_eject <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                S_AUTH: begin
                    if (auth_done) begin
                        if (auth_ok) begin
                            session_active <= 1'b1;
                            st             <= S_MENU;
                        end else begin
                            fail_count <= fail_next;
                            if (fail_next == TRIES) begin
                                for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                                    if (acc_num == 4'(i)) begin
                                        lock_tbl[i] <= 1'b1;
                                    end
                                end
                                st         <= S_LOCKED;
                                locked_out <= 1'b1;
                            end else begin
                                st   <= S_PIN;
                                pin  <= '0;
                                dcnt <= '0;
                            end
                        end
                    end
                end

                S_MENU: begin
                    // A menu selection outranks a coincident keypad strobe.
                    if (op_sel_valid) begin
                        if (op_sel == OP_EXIT) begin
                            st         <= S_EJECT;
                            card_eject <= 1'b1;
                        end else begin
                            operation <= op_sel;
                            op_valid  <= 1'b1;
                            st        <= S_BUSY;
                        end
                    end else if (key_valid) begin
                        if (key_code == K_CANCEL) begin
                            st         <= S_EJECT;
                            card_eject <= 1'b1;
                        end
                    end else if (to_hit) begin
                        st         <= S_EJECT;
                        card_eject <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                S_BUSY: begin
                    if (txn_done) begin
                        st <= S_MENU;
                    end
                end

                S_LOCKED: begin
                    st         <= S_EJECT;
                    card_eject <= 1'b1;
                end

                S_EJECT: begin
                    session_active <= 1'b0;
                    pin            <= '0;
                    dcnt           <= '0;
                    fail_count     <= '0;
                    operation      <= '0;
                    st             <= S_IDLE;
                end

                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: per-cycle stimulus/expectation table plus timeout and async-reset sequences.
module tb_atm_session_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        card_insert;
    logic [3:0]  card_acc_num;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        auth_done;
    logic        auth_ok;
    logic        op_sel_valid;
    logic [2:0]  op_sel;
    logic        txn_done;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic        pin_valid;
    logic [2:0]  operation;
    logic        op_valid;
    logic        session_active;
    logic        card_eject;
    logic        locked_out;
    logic [1:0]  fail_count;
    logic [2:0]  state;

    atm_session_ctrl #(
        .MAX_TRIES(3),
        .TIMEOUT_CYCLES(8),
        .NUM_ACCOUNTS(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .card_insert(card_insert),
        .card_acc_num(card_acc_num),
        .key_valid(key_valid),
        .key_code(key_code),
        .auth_done(auth_done),
        .auth_ok(auth_ok),
        .op_sel_valid(op_sel_valid),
        .op_sel(op_sel),
        .txn_done(txn_done),
        .acc_num(acc_num),
        .pin(pin),
        .pin_valid(pin_valid),
        .operation(operation),
        .op_valid(op_valid),
        .session_active(session_active),
        .card_eject(card_eject),
        .locked_out(locked_out),
        .fail_count(fail_count),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ci;
        logic [3:0] can;
        logic       kv;
        logic [3:0] kc;
        logic       ad;
        logic       ao;
        logic       osv;
        logic [2:0] os;
        logic       td;
    } in_t;

    typedef struct packed {
        logic [2:0]  st;
        logic [3:0]  acc;
        logic [15:0] pin;
        logic        pv;
        logic [2:0]  op;
        logic        ov;
        logic        sa;
        logic        ej;
        logic        lo;
        logic [1:0]  fc;
    } out_t;

    typedef struct packed {
        in_t  stim;
        out_t exp;
    } vec_t;

    vec_t tbl[$];
    out_t act;
    int   checks = 0;
    int   errors = 0;

    assign act = {state, acc_num, pin, pin_valid, operation, op_valid,
                  session_active, card_eject, locked_out, fail_count};

    function automatic in_t nop();
        in_t v = '0;
        return v;
    endfunction

    function automatic in_t card(input int a);
        in_t v = '0;
        v.ci  = 1'b1;
        v.can = 4'(a);
        return v;
    endfunction

    function automatic in_t key(input int k);
        in_t v = '0;
        v.kv = 1'b1;
        v.kc = 4'(k);
        return v;
    endfunction

    function automatic in_t auth(input int ok);
        in_t v = '0;
        v.ad = 1'b1;
        v.ao = 1'(ok);
        return v;
    endfunction

    function automatic in_t op(input int o);
        in_t v = '0;
        v.osv = 1'b1;
        v.os  = 3'(o);
        return v;
    endfunction

    function automatic in_t opkey(input int o, input int k);
        in_t v = op(o);
        v.kv = 1'b1;
        v.kc = 4'(k);
        return v;
    endfunction

    function automatic in_t txn();
        in_t v = '0;
        v.td = 1'b1;
        return v;
    endfunction

    function automatic out_t ex(input int st, input int acc, input int p, input int pv,
                                input int o, input int ov, input int sa, input int ej,
                                input int lo, input int fc);
        out_t r;
        r.st  = 3'(st);
        r.acc = 4'(acc);
        r.pin = 16'(p);
        r.pv  = 1'(pv);
        r.op  = 3'(o);
        r.ov  = 1'(ov);
        r.sa  = 1'(sa);
        r.ej  = 1'(ej);
        r.lo  = 1'(lo);
        r.fc  = 2'(fc);
        return r;
    endfunction

    function automatic void add(input in_t s, input out_t e);
        vec_t v;
        v.stim = s;
        v.exp  = e;
        tbl.push_back(v);
    endfunction

    task automatic apply(input in_t v);
        card_insert  = v.ci;
        card_acc_num = v.can;
        key_valid    = v.kv;
        key_code     = v.kc;
        auth_done    = v.ad;
        auth_ok      = v.ao;
        op_sel_valid = v.osv;
        op_sel       = v.os;
        txn_done     = v.td;
    endtask

    task automatic check(input string nm, input out_t e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s got st=%0d acc=%0d pin=%h pv=%b op=%0d ov=%b sa=%b ej=%b lo=%b fc=%0d expected st=%0d acc=%0d pin=%h pv=%b op=%0d ov=%b sa=%b ej=%b lo=%b fc=%0d",
                     nm, act.st, act.acc, act.pin, act.pv, act.op, act.ov, act.sa, act.ej, act.lo, act.fc,
                     e.st, e.acc, e.pin, e.pv, e.op, e.ov, e.sa, e.ej, e.lo, e.fc);
        end
    endtask

    task automatic step(input in_t v, input out_t e, input string nm);
        @(negedge clk);
        apply(v);
        @(posedge clk);
        #1;
        check(nm, e);
    endtask

    // States: IDLE 0, PIN 1, AUTH 2, MENU 3, BUSY 4, LOCKED 5, EJECT 6.
    // ex(state, acc, pin, pin_valid, operation, op_valid, session_active, card_eject, locked_out, fail_count)
    initial begin
        add(card(3),   ex(1, 3, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
        add(key(1),    ex(1, 3, 16'h0001, 0, 0, 0, 0, 0, 0, 0));
        add(key(2),    ex(1, 3, 16'h0012, 0, 0, 0, 0, 0, 0, 0));
        add(key(3),    ex(1, 3, 16'h0123, 0, 0, 0, 0, 0, 0, 0));
        add(key(4),    ex(1, 3, 16'h1234, 0, 0, 0, 0, 0, 0, 0));
        add(key(11),   ex(2, 3, 16'h1234, 1, 0, 0, 0, 0, 0, 0));
        add(nop(),     ex(2, 3, 16'h1234, 0, 0, 0, 0, 0, 0, 0));
        add(auth(1),   ex(3, 3, 16'h1234, 0, 0, 0, 1, 0, 0, 0));
        add(op(2),     ex(4, 3, 16'h1234, 0, 2, 1, 1, 0, 0, 0));
        add(key(12),   ex(4, 3, 16'h1234, 0, 2, 0, 1, 0, 0, 0));
        add(op(5),     ex(4, 3, 16'h1234, 0, 2, 0, 1, 0, 0, 0));
        add(txn(),     ex(3, 3, 16'h1234, 0, 2, 0, 1, 0, 0, 0));
        add(op(7),     ex(6, 3, 16'h1234, 0, 2, 0, 1, 1, 0, 0));
        add(nop(),     ex(0, 3, 16'h0000, 0, 0, 0, 0, 0, 0, 0));

        add(card(5),   ex(1, 5, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
        add(key(9),    ex(1, 5, 16'h0009, 0, 0, 0, 0, 0, 0, 0));
        add(key(8),    ex(1, 5, 16'h0098, 0, 0, 0, 0, 0, 0, 0));
        add(key(10),   ex(1, 5, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
        add(key(5),    ex(1, 5, 16'h0005, 0, 0, 0, 0, 0, 0, 0));
        add(key(6),    ex(1, 5, 16'h0056, 0, 0, 0, 0, 0, 0, 0));
        add(key(7),    ex(1, 5, 16'h0567, 0, 0, 0, 0, 0, 0, 0));
        add(key(8),    ex(1, 5, 16'h5678, 0, 0, 0, 0, 0, 0, 0));
        add(key(9),    ex(1, 5, 16'h5678, 0, 0, 0, 0, 0, 0, 0));
        add(key(11),   ex(2, 5, 16'h5678, 1, 0, 0, 0, 0, 0, 0));
        add(auth(0),   ex(1, 5, 16'h0000, 0, 0, 0, 0, 0, 0, 1));
        add(key(1),    ex(1, 5, 16'h0001, 0, 0, 0, 0, 0, 0, 1));
        add(key(2),    ex(1, 5, 16'h0012, 0, 0, 0, 0, 0, 0, 1));
        add(key(3),    ex(1, 5, 16'h0123, 0, 0, 0, 0, 0, 0, 1));
        add(key(11),   ex(1, 5, 16'h0123, 0, 0, 0, 0, 0, 0, 1));
        add(key(14),   ex(1, 5, 16'h0123, 0, 0, 0, 0, 0, 0, 1));
        add(key(12),   ex(6, 5, 16'h0123, 0, 0, 0, 0, 1, 0, 1));
        add(nop(),     ex(0, 5, 16'h0000, 0, 0, 0, 0, 0, 0, 0));

        add(card(2),   ex(1, 2, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
        for (int t = 0; t < 3; t++) begin
            add(key(7),  ex(1, 2, 16'h0007, 0, 0, 0, 0, 0, 0, t));
            add(key(7),  ex(1, 2, 16'h0077, 0, 0, 0, 0, 0, 0, t));
            add(key(7),  ex(1, 2, 16'h0777, 0, 0, 0, 0, 0, 0, t));
            add(key(7),  ex(1, 2, 16'h7777, 0, 0, 0, 0, 0, 0, t));
            add(key(11), ex(2, 2, 16'h7777, 1, 0, 0, 0, 0, 0, t));
            if (t < 2) add(auth(0), ex(1, 2, 16'h0000, 0, 0, 0, 0, 0, 0, t + 1));
            else       add(auth(0), ex(5, 2, 16'h7777, 0, 0, 0, 0, 0, 1, 3));
        end
        add(nop(),     ex(6, 2, 16'h7777, 0, 0, 0, 0, 1, 0, 3));
        add(nop(),     ex(0, 2, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
        add(card(2),   ex(5, 2, 16'h0000, 0, 0, 0, 0, 0, 1, 0));
        add(nop(),     ex(6, 2, 16'h0000, 0, 0, 0, 0, 1, 0, 0));
        add(nop(),     ex(0, 2, 16'h0000, 0, 0, 0, 0, 0, 0, 0));

        add(card(1),   ex(1, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
        add(card(7),   ex(1, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
        for (int d = 0; d < 4; d++) add(key(0), ex(1, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
        add(key(11),   ex(2, 1, 16'h0000, 1, 0, 0, 0, 0, 0, 0));
        add(key(12),   ex(2, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
        add(auth(1),   ex(3, 1, 16'h0000, 0, 0, 0, 1, 0, 0, 0));
        add(opkey(3, 12), ex(4, 1, 16'h0000, 0, 3, 1, 1, 0, 0, 0));
        add(txn(),     ex(3, 1, 16'h0000, 0, 3, 0, 1, 0, 0, 0));
        add(key(12),   ex(6, 1, 16'h0000, 0, 3, 0, 1, 1, 0, 0));
        add(nop(),     ex(0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0));

        rst = 1'b1;
        apply(nop());
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", '0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].stim, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Inactivity timeout in PIN_ENTRY, then a key in the last idle cycle restarting the count.
        step(card(4), ex(1, 4, 0, 0, 0, 0, 0, 0, 0, 0), "to_enter");
        for (int i = 0; i < 7; i++) step(nop(), ex(1, 4, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("to_wait%0d", i));
        step(nop(), ex(6, 4, 0, 0, 0, 0, 0, 1, 0, 0), "to_eject");
        step(nop(), ex(0, 4, 0, 0, 0, 0, 0, 0, 0, 0), "to_idle");
        step(card(4), ex(1, 4, 0, 0, 0, 0, 0, 0, 0, 0), "tr_enter");
        for (int i = 0; i < 7; i++) step(nop(), ex(1, 4, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("tr_wait%0d", i));
        step(key(5), ex(1, 4, 16'h0005, 0, 0, 0, 0, 0, 0, 0), "tr_key_restart");
        for (int i = 0; i < 7; i++) step(nop(), ex(1, 4, 16'h0005, 0, 0, 0, 0, 0, 0, 0), $sformatf("tr_rewait%0d", i));
        step(nop(), ex(6, 4, 16'h0005, 0, 0, 0, 0, 1, 0, 0), "tr_eject");
        step(nop(), ex(0, 4, 0, 0, 0, 0, 0, 0, 0, 0), "tr_idle");

        // Asynchronous reset while BUSY, lock table cleared, out-of-range account.
        step(card(1), ex(1, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0), "rb_card");
        step(key(1),  ex(1, 1, 16'h0001, 0, 0, 0, 0, 0, 0, 0), "rb_k1");
        step(key(2),  ex(1, 1, 16'h0012, 0, 0, 0, 0, 0, 0, 0), "rb_k2");
        step(key(3),  ex(1, 1, 16'h0123, 0, 0, 0, 0, 0, 0, 0), "rb_k3");
        step(key(4),  ex(1, 1, 16'h1234, 0, 0, 0, 0, 0, 0, 0), "rb_k4");
        step(key(11), ex(2, 1, 16'h1234, 1, 0, 0, 0, 0, 0, 0), "rb_enter");
        step(auth(1), ex(3, 1, 16'h1234, 0, 0, 0, 1, 0, 0, 0), "rb_auth");
        step(op(1),   ex(4, 1, 16'h1234, 0, 1, 1, 1, 0, 0, 0), "rb_busy");
        @(negedge clk);
        apply(nop());
        #2 rst = 1'b1;
        #1 check("rst_async", '0);
        #1 rst = 1'b0;
        step(card(2),  ex(1, 2, 0, 0, 0, 0, 0, 0, 0, 0), "unlock_after_rst");
        step(key(12),  ex(6, 2, 0, 0, 0, 0, 0, 1, 0, 0), "unlock_cancel");
        step(nop(),    ex(0, 2, 0, 0, 0, 0, 0, 0, 0, 0), "unlock_idle");
        step(card(12), ex(5, 12, 0, 0, 0, 0, 0, 0, 1, 0), "bad_acc_locked");
        step(nop(),    ex(6, 12, 0, 0, 0, 0, 0, 1, 0, 0), "bad_acc_eject");
        step(nop(),    ex(0, 12, 0, 0, 0, 0, 0, 0, 0, 0), "bad_acc_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Upstream front-end of the ATM transaction core. It owns the card/keypad session:
- accepts card insertion and BCD keypad digits, and packs the 4-digit PIN;
- presents acc_num/pin to the authenticator and tracks failed attempts, locking accounts after MAX_TRIES;
- forwards the selected operation to the transaction core and handles inactivity timeout and card eject.

Parameters:
MAX_TRIES, 3, failed PIN attempts before the account is locked (1..3)
TIMEOUT_CYCLES, 1000, idle cycles in PIN_ENTRY/MENU before forced eject
NUM_ACCOUNTS, 10, number of valid account indices (0..NUM_ACCOUNTS-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
card_insert  in  1  one-cycle pulse, card present
card_acc_num  in  4  account number read from card, sampled with card_insert
key_valid  in  1  one-cycle keypad strobe
key_code  in  4  0-9 digit, 10 clear, 11 enter, 12 cancel, 13-15 ignored
auth_done  in  1  authenticator result strobe
auth_ok  in  1  authenticator verdict, valid with auth_done
op_sel_valid  in  1  menu selection strobe
op_sel  in  3  operation code; 3'd7 = exit
txn_done  in  1  transaction core finished current operation
acc_num  out  4  registered account number to authenticator/core
pin  out  16  packed BCD PIN, most recent digit in [3:0]
pin_valid  out  1  one-cycle pulse requesting authentication
operation  out  3  registered operation code to core
op_valid  out  1  one-cycle pulse, operation issued
session_active  out  1  high from successful auth until eject
card_eject  out  1  one-cycle eject pulse
locked_out  out  1  high while in LOCKED state
fail_count  out  2  failed attempts in current session
state  out  3  current FSM state (debug)

Behaviour:
- Reset (async, immediate): all outputs 0; lock table cleared; state = IDLE.
- States: IDLE=0, PIN_ENTRY=1, AUTH_WAIT=2, MENU=3, BUSY=4, LOCKED=5, EJECT=6.
- IDLE, card_insert:
  - acc_num <= card_acc_num.
  - If card_acc_num >= NUM_ACCOUNTS or lock bit set, go to LOCKED.
  - Else go to PIN_ENTRY; pin <= 0; digit count <= 0; fail_count <= 0.
- IDLE ignores all other inputs. card_insert outside IDLE is ignored.
- PIN_ENTRY keys:
  - Digit with count<4: pin <= {pin[11:0], key_code}; count++.
  - Digit with count==4: ignored.
  - Clear: pin <= 0; count <= 0.
  - Enter with count==4: pin_valid pulses the next cycle; go to AUTH_WAIT.
  - Enter with count<4: ignored.
  - Cancel: go to EJECT.
- AUTH_WAIT: keys ignored; no timeout. On auth_done:
  - auth_ok=1: session_active <= 1; go to MENU.
  - auth_ok=0: fail_count++. If the new count == MAX_TRIES, set lock bit [acc_num] and go to LOCKED. Else go to PIN_ENTRY with pin and count cleared.
- MENU, op_sel_valid:
  - op_sel==7: go to EJECT.
  - Else operation <= op_sel; op_valid pulses one cycle; go to BUSY.
  - Cancel key also goes to EJECT.
- BUSY: op_sel and keys ignored; txn_done returns to MENU. No timeout in BUSY.
- LOCKED: locked_out=1 for exactly one cycle, then EJECT.
- EJECT: card_eject=1 for one cycle; session_active, pin, fail_count, operation cleared; next state IDLE. acc_num holds its last value.
- Timeout counter:
  - Cleared on state entry and on any key_valid or op_sel_valid.
  - Increments only in PIN_ENTRY and MENU.
  - Reaching TIMEOUT_CYCLES-1 forces EJECT on the next edge.
  - A strobe in that same cycle takes precedence and resets the counter.
- Simultaneous key_valid and op_sel_valid in MENU: op_sel_valid wins.
- Lock table: NUM_ACCOUNTS bits; survives sessions; cleared only by rst.
- Latency: input strobe to registered output is 1 cycle for pin_valid, op_valid and card_eject.

Test Plan:
- Card acc 3, keys 1,2,3,4, enter -> pin=16'h1234, pin_valid pulse, state=AUTH_WAIT; auth_done/ok=1 -> session_active=1, MENU.
- Keys 9,8, clear, 5,6,7,8,9, enter -> pin=16'h5678, fifth digit ignored; enter after only 3 digits -> no pin_valid.
- Acc 2, three auth_done with auth_ok=0 -> fail_count 1,2 then LOCKED, locked_out pulse, card_eject. Reinsert acc 2 -> immediate LOCKED/eject. Acc 2 unlocks only after rst.
- MENU, op_sel=3'd2 -> operation=2, op_valid 1 cycle, BUSY; txn_done -> MENU; op_sel=7 -> card_eject, IDLE, session_active=0.
- PIN_ENTRY with no keys for TIMEOUT_CYCLES (set to 8) -> card_eject at cycle 8. A key at cycle 7 restarts the count.
- rst asserted in BUSY mid-cycle -> outputs 0 and state IDLE without waiting for a clock edge; card_acc_num=12 -> LOCKED, eject.
